spi_tx: RTL and testbench

SPI mode-0 master transmitter (CPOL=0, CPHA=0), MSB first, one byte per chip-select frame. It accepts a byte on a valid/ready handshake, then generates SCLK, CS_n and MOSI. It is the sending end of the link whose receive side delivers the bit/enable stream consumed by the state-machine block. Runs on the system clock; SCLK is derived by a counter.

---
 rtl/spi_tx.sv | 137 +++++++++++++
 tb/tb_spi_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx.sv
// SPI mode-0 master transmitter (CPOL=0, CPHA=0), MSB first, one byte per
// chip-select frame. A byte is accepted on a valid/ready handshake. The frame
// is built from a lead-in half-period, 16 SCLK half-periods and a trailing
// half-period. Every output comes straight from a flop.
module spi_tx #(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Tx_Dv,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Done,
  output logic       o_Spi_Clk,
  output logic       o_Spi_Cs_n,
  output logic       o_Spi_Mosi
);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL
  } state_t;

  localparam logic [7:0] HALF_MAX = 8'(CLKS_PER_HALF_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] edge_q, edge_d;
  logic [7:0] shreg_q, shreg_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       sclk_q, sclk_d;
  logic       cs_n_q, cs_n_d;
  logic       mosi_q, mosi_d;
  logic       half_end;

  assign half_end = (cnt_q == HALF_MAX);

  // Next-state and next-output logic; outputs are precomputed one cycle ahead
  always_comb begin
    state_d = state_q;
    cnt_d   = half_end ? 8'd0 : cnt_q + 8'd1;
    edge_d  = edge_q;
    shreg_d = shreg_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;

    unique case (state_q)
      IDLE: begin
        cnt_d   = 8'd0;
        edge_d  = 4'd0;
        ready_d = 1'b1;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        if (i_Tx_Dv && ready_q) begin
          state_d = LEAD;
          shreg_d = i_Tx_Byte;
          ready_d = 1'b0;
          cs_n_d  = 1'b0;
          mosi_d  = i_Tx_Byte[7];
        end
      end
      LEAD: begin
        if (half_end) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          edge_d  = 4'd0;
        end
      end
      SHIFT: begin
        if (half_end) begin
          if (edge_q == 4'd15) begin
            state_d = TRAIL;
            sclk_d  = 1'b0;
          end else begin
            edge_d = edge_q + 4'd1;
            sclk_d = ~sclk_q;
            // Falls after rises 1..7 present the next bit; the 8th fall keeps byte[0]
            if (sclk_q && (edge_q != 4'd14)) begin
              shreg_d = {shreg_q[6:0], 1'b0};
              mosi_d  = shreg_q[6];
            end
          end
        end
      end
      TRAIL: begin
        if (half_end) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          ready_d = 1'b1;
          shreg_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset that aborts any frame
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      edge_q  <= 4'd0;
      shreg_q <= 8'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      shreg_q <= shreg_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
    end
  end

  assign o_Tx_Ready = ready_q;
  assign o_Tx_Done  = done_q;
  assign o_Spi_Clk  = sclk_q;
  assign o_Spi_Cs_n = cs_n_q;
  assign o_Spi_Mosi = mosi_q;

endmodule

// File: tb/tb_spi_tx.sv
// Self-checking bench for spi_tx. Three instances with different half-bit
// lengths run side by side. Each instance has its own inputs and its own
// frame-timeline model. Directed scenarios pin the model with literal
// expectations, and a randomized phase follows.
module tb_spi_tx;

   localparam int NDUT = 3;
   localparam int HS [NDUT] = '{2, 1, 3};

   logic clk;
   logic [NDUT-1:0] rst, dv, txReady, txDone, spiClk, spiCsN, spiMosi;
   logic [7:0] txByte [NDUT];

   // One DUT per half-bit length, each with independent stimulus
   for (genvar g = 0; g < NDUT; g++) begin : gDut
      spi_tx #(.CLKS_PER_HALF_BIT(HS[g])) uDut (
         .i_Clk(clk),
         .i_Rst(rst[g]),
         .i_Tx_Dv(dv[g]),
         .i_Tx_Byte(txByte[g]),
         .o_Tx_Ready(txReady[g]),
         .o_Tx_Done(txDone[g]),
         .o_Spi_Clk(spiClk[g]),
         .o_Spi_Cs_n(spiCsN[g]),
         .o_Spi_Mosi(spiMosi[g])
      );
   end

   // Free-running system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int edgeCount = 0;

   // Model state: the accept edge and byte of the current frame, per DUT
   bit         mValid [NDUT];
   bit         mLive  [NDUT];
   int         mStart [NDUT];
   logic [7:0] mByte  [NDUT];

   // Monitor state: the waveform as a receiver would see it
   logic       prevSclk [NDUT];
   logic       prevCs   [NDUT];
   logic [7:0] rxBits   [NDUT];
   logic [7:0] lastRx   [NDUT];
   int rises [NDUT];
   int lastRises [NDUT];
   int csLow [NDUT];
   int lastCsLow [NDUT];
   int csHighRun [NDUT];
   int lastGap [NDUT];
   int framesEnded [NDUT];
   int doneCount [NDUT];
   int lastDoneCyc [NDUT];
   int idleEdges [NDUT];

   // Expected outputs after edge nn. They follow from the frame timeline:
   // H lead cycles, 16 half-periods of H cycles, H trail cycles, then Done.
   function automatic void expOut(input int g, input int nn,
                                  output logic eReady, output logic eDone,
                                  output logic eSclk, output logic eCsN,
                                  output logic eMosi);
      int h, t, j, k;
      h = HS[g];
      eReady = 1'b1; eDone = 1'b0; eSclk = 1'b0; eCsN = 1'b1; eMosi = 1'b0;
      if (mValid[g]) begin
         t = nn - mStart[g];
         if (t >= 0 && t < 18 * h) begin
            eReady = 1'b0;
            eCsN   = 1'b0;
            if (t < h) begin
               eMosi = mByte[g][7];
            end else if (t < 17 * h) begin
               j = (t - h) / h + 1;
               eSclk = (j % 2) == 1;
               k = j / 2;
               if (k > 7) k = 7;
               eMosi = mByte[g][7 - k];
            end else begin
               eMosi = mByte[g][0];
            end
         end else if (t == 18 * h) begin
            eDone = 1'b1;
         end
      end
   endfunction

   task automatic checkOutput(input string name, input int g,
                              input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s dut%0d (H=%0d) edge %0d: got %0h, expected %0h",
                  name, g, HS[g], edgeCount, act, req);
      end
   endtask

   task automatic applyStimulus(input int g, input logic r, input logic v,
                                input logic [7:0] b);
      rst[g]    = r;
      dv[g]     = v;
      txByte[g] = b;
   endtask

   // One clock: advance the model at posedge, compare and monitor at negedge
   task automatic tick();
      logic r, d, c, cs, m;
      @(posedge clk);
      for (int g = 0; g < NDUT; g++) begin
         expOut(g, edgeCount, r, d, c, cs, m);
         if (rst[g]) begin
            mValid[g] = 1'b0;
            mLive[g]  = 1'b1;
         end else if (mLive[g] && r && dv[g]) begin
            mValid[g] = 1'b1;
            mStart[g] = edgeCount + 1;
            mByte[g]  = txByte[g];
         end
      end
      edgeCount++;
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
         if (mLive[g]) begin
            expOut(g, edgeCount, r, d, c, cs, m);
            checkOutput("ready", g, txReady[g], r);
            checkOutput("done", g, txDone[g], d);
            checkOutput("sclk", g, spiClk[g], c);
            checkOutput("cs_n", g, spiCsN[g], cs);
            checkOutput("mosi", g, spiMosi[g], m);
         end
         if (prevCs[g] === 1'b0 && spiCsN[g] === 1'b1) begin
            lastRx[g]    = rxBits[g];
            lastRises[g] = rises[g];
            lastCsLow[g] = csLow[g];
            framesEnded[g]++;
            csHighRun[g] = 0;
         end
         if (prevCs[g] === 1'b1 && spiCsN[g] === 1'b0) begin
            lastGap[g]   = csHighRun[g];
            csHighRun[g] = 0;
            csLow[g]     = 0;
            rises[g]     = 0;
            rxBits[g]    = 8'h00;
         end
         if (spiCsN[g] === 1'b1) csHighRun[g]++;
         else csLow[g]++;
         if (prevSclk[g] === 1'b0 && spiClk[g] === 1'b1) begin
            rxBits[g] = {rxBits[g][6:0], spiMosi[g]};
            rises[g]++;
         end
         if (prevCs[g] === 1'b1 && spiCsN[g] === 1'b1 && prevSclk[g] !== spiClk[g]
             && mLive[g])
            idleEdges[g]++;
         if (txDone[g] === 1'b1) begin
            doneCount[g]++;
            lastDoneCyc[g] = edgeCount;
         end
         prevSclk[g] = spiClk[g];
         prevCs[g]   = spiCsN[g];
      end
   endtask

   task automatic waitDone(input int g, input int budget);
      int start;
      start = doneCount[g];
      for (int i = 0; i < budget && doneCount[g] == start; i++) tick();
      if (doneCount[g] == start) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout dut%0d: no Done within %0d cycles", g, budget);
      end
   endtask

   task automatic waitRises(input int g, input int k, input int budget);
      for (int i = 0; i < budget && rises[g] < k; i++) tick();
      if (rises[g] < k) begin
         checks++;
         errors++;
         $display("[TB] FAIL rise_timeout dut%0d: %0d rises, wanted %0d", g, rises[g], k);
      end
   endtask

   // Directed scenarios, then randomized traffic on every DUT
   initial begin
      int dvCyc, d1, dc, fe;
      for (int g = 0; g < NDUT; g++) begin
         mValid[g] = 0; mLive[g] = 0; mStart[g] = 0; mByte[g] = 0;
         rxBits[g] = 0; lastRx[g] = 0; rises[g] = 0; lastRises[g] = 0;
         csLow[g] = 0; lastCsLow[g] = 0; csHighRun[g] = 0; lastGap[g] = 0;
         framesEnded[g] = 0; doneCount[g] = 0; lastDoneCyc[g] = 0; idleEdges[g] = 0;
         prevSclk[g] = 1'bx; prevCs[g] = 1'bx;
         applyStimulus(g, 1'b1, 1'b1, 8'hFF);
      end

      $display("[TB] reset with valid held high");
      repeat (3) tick();
      for (int g = 0; g < NDUT; g++) begin
         checkOutput("rst_ready", g, txReady[g], 1);
         checkOutput("rst_cs_n", g, spiCsN[g], 1);
         checkOutput("rst_sclk", g, spiClk[g], 0);
         checkOutput("rst_mosi", g, spiMosi[g], 0);
         checkOutput("rst_done", g, txDone[g], 0);
         applyStimulus(g, 1'b0, 1'b0, 8'h00);
      end
      tick();
      checkOutput("post_rst_idle_cs", 0, spiCsN[0], 1);

      $display("[TB] single byte 0xA5, H=2");
      dvCyc = edgeCount;
      applyStimulus(0, 1'b0, 1'b1, 8'hA5);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 8'h00);
      checkOutput("a5_busy", 0, txReady[0], 0);
      waitDone(0, 100);
      checkOutput("a5_bits", 0, lastRx[0], 8'hA5);
      checkOutput("a5_rises", 0, lastRises[0], 8);
      checkOutput("a5_cs_low", 0, lastCsLow[0], 36);
      checkOutput("a5_latency", 0, lastDoneCyc[0] - dvCyc, 37);

      $display("[TB] back-to-back 0x3C, 0xC3, H=2");
      applyStimulus(0, 1'b0, 1'b1, 8'h3C);
      tick();
      applyStimulus(0, 1'b0, 1'b1, 8'hC3);
      waitDone(0, 100);
      d1 = lastDoneCyc[0];
      checkOutput("b2b_bits1", 0, lastRx[0], 8'h3C);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 8'h00);
      waitDone(0, 100);
      checkOutput("b2b_bits2", 0, lastRx[0], 8'hC3);
      checkOutput("b2b_gap", 0, lastGap[0], 1);
      checkOutput("b2b_done_spacing", 0, lastDoneCyc[0] - d1, 37);

      $display("[TB] busy ignore, H=2");
      applyStimulus(0, 1'b0, 1'b1, 8'h00);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 8'h00);
      waitRises(0, 2, 50);
      applyStimulus(0, 1'b0, 1'b1, 8'hFF);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 8'h00);
      dc = doneCount[0];
      waitDone(0, 100);
      checkOutput("busy_bits", 0, lastRx[0], 8'h00);
      fe = framesEnded[0];
      repeat (60) tick();
      checkOutput("busy_one_done", 0, doneCount[0] - dc, 1);
      checkOutput("busy_no_frame", 0, framesEnded[0] - fe, 0);
      checkOutput("busy_idle_cs", 0, spiCsN[0], 1);

      $display("[TB] reset mid-frame, H=2");
      applyStimulus(0, 1'b0, 1'b1, 8'h81);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 8'h00);
      waitRises(0, 3, 60);
      dc = doneCount[0];
      applyStimulus(0, 1'b1, 1'b0, 8'h00);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 8'h00);
      checkOutput("abort_cs_n", 0, spiCsN[0], 1);
      checkOutput("abort_sclk", 0, spiClk[0], 0);
      checkOutput("abort_done", 0, txDone[0], 0);
      checkOutput("abort_ready", 0, txReady[0], 1);
      repeat (60) tick();
      checkOutput("abort_no_done", 0, doneCount[0] - dc, 0);
      applyStimulus(0, 1'b0, 1'b1, 8'h81);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 8'h00);
      waitDone(0, 100);
      checkOutput("resend_bits", 0, lastRx[0], 8'h81);
      checkOutput("resend_rises", 0, lastRises[0], 8);

      $display("[TB] single byte 0x5A, H=1");
      dvCyc = edgeCount;
      applyStimulus(1, 1'b0, 1'b1, 8'h5A);
      tick();
      applyStimulus(1, 1'b0, 1'b0, 8'h00);
      waitDone(1, 60);
      checkOutput("h1_bits", 1, lastRx[1], 8'h5A);
      checkOutput("h1_cs_low", 1, lastCsLow[1], 18);
      checkOutput("h1_latency", 1, lastDoneCyc[1] - dvCyc, 19);

      $display("[TB] single byte 0xE7, H=3");
      dvCyc = edgeCount;
      applyStimulus(2, 1'b0, 1'b1, 8'hE7);
      tick();
      applyStimulus(2, 1'b0, 1'b0, 8'h00);
      waitDone(2, 100);
      checkOutput("h3_bits", 2, lastRx[2], 8'hE7);
      checkOutput("h3_cs_low", 2, lastCsLow[2], 54);
      checkOutput("h3_latency", 2, lastDoneCyc[2] - dvCyc, 55);

      $display("[TB] randomized traffic");
      repeat (2000) begin
         for (int g = 0; g < NDUT; g++)
            applyStimulus(g, $urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                          8'($urandom));
         tick();
      end
      for (int g = 0; g < NDUT; g++) applyStimulus(g, 1'b0, 1'b0, 8'h00);
      repeat (70) tick();

      for (int g = 0; g < NDUT; g++)
         checkOutput("sclk_edges_while_idle", g, idleEdges[g], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
